// File: rtl/ahb3lite_interconnect_slave_port.sv
// ============================================================================
// Module   : ahb3lite_interconnect_slave_port
// Purpose  : Slave-side port of an AHB3-Lite multi-layer switch. Arbitrates
//            among master-port requests, muxes the winner's address/control
//            and the data-phase owner's write data onto the slave, and routes
//            the slave response back to the master ports.
// Options  : AHB3LITE_IC_RR_ARB_EN - round-robin tie break among the highest
//            priority requesters (default: lowest index wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb3lite_interconnect_slave_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
) (
    input  logic                               HRESETn,
    input  logic                               HCLK,

    input  logic [MASTERS-1:0][2:0]            mst_priority,
    input  logic [MASTERS-1:0]                 mst_HSEL,
    input  logic [MASTERS-1:0][HADDR_SIZE-1:0] mst_HADDR,
    input  logic [MASTERS-1:0][HDATA_SIZE-1:0] mst_HWDATA,
    input  logic [MASTERS-1:0]                 mst_HWRITE,
    input  logic [MASTERS-1:0][2:0]            mst_HSIZE,
    input  logic [MASTERS-1:0][2:0]            mst_HBURST,
    input  logic [MASTERS-1:0][3:0]            mst_HPROT,
    input  logic [MASTERS-1:0][1:0]            mst_HTRANS,
    input  logic [MASTERS-1:0]                 mst_HMASTLOCK,
    input  logic [MASTERS-1:0]                 mst_can_switch,
    output logic [HDATA_SIZE-1:0]              mst_HRDATA,
    output logic                               mst_HREADYOUT,
    output logic [MASTERS-1:0]                 mst_HRESP,
    output logic [MASTERS-1:0]                 master_granted,

    output logic                               slv_HSEL,
    output logic [HADDR_SIZE-1:0]              slv_HADDR,
    output logic [HDATA_SIZE-1:0]              slv_HWDATA,
    output logic                               slv_HWRITE,
    output logic [2:0]                         slv_HSIZE,
    output logic [2:0]                         slv_HBURST,
    output logic [3:0]                         slv_HPROT,
    output logic [1:0]                         slv_HTRANS,
    output logic                               slv_HMASTLOCK,
    output logic                               slv_HREADY,
    input  logic [HDATA_SIZE-1:0]              slv_HRDATA,
    input  logic                               slv_HREADYOUT,
    input  logic                               slv_HRESP
);

    localparam int                     MASTER_BITS = $clog2(MASTERS);
    localparam logic [MASTER_BITS:0]   C_MASTERS   = MASTERS[MASTER_BITS:0];

    logic [MASTER_BITS-1:0] addr_owner_q, addr_owner_d;
    logic [MASTER_BITS-1:0] data_owner_q, data_owner_d;
    logic                   data_active_q, data_active_d;

    logic [MASTER_BITS:0]   start_w;
    logic [MASTER_BITS:0]   idx_w;
    logic [MASTER_BITS-1:0] winner_w;
    logic [2:0]             best_prio_w;
    logic                   found_w;

    // First index examined by the arbiter; earlier-examined masters win ties.
    always_comb begin
`ifdef AHB3LITE_IC_RR_ARB_EN
        start_w = {1'b0, addr_owner_q} + 1'b1;
        if (start_w >= C_MASTERS) start_w = start_w - C_MASTERS;
`else
        start_w = '0;
`endif
    end

    // Highest priority requester wins; with no requester the bus stays parked.
    always_comb begin
        found_w     = 1'b0;
        best_prio_w = '0;
        winner_w    = addr_owner_q;
        idx_w       = '0;
        for (int k = 0; k < MASTERS; k++) begin
            idx_w = start_w + k[MASTER_BITS:0];
            if (idx_w >= C_MASTERS) idx_w = idx_w - C_MASTERS;
            if (mst_HSEL[idx_w[MASTER_BITS-1:0]] &&
                (!found_w || (mst_priority[idx_w[MASTER_BITS-1:0]] > best_prio_w))) begin
                found_w     = 1'b1;
                best_prio_w = mst_priority[idx_w[MASTER_BITS-1:0]];
                winner_w    = idx_w[MASTER_BITS-1:0];
            end
        end
    end

    // Ownership moves only on a ready edge, and the address owner only when it
    // allows a switch or has stopped requesting (locks, bursts, wait states).
    always_comb begin
        addr_owner_d  = addr_owner_q;
        data_owner_d  = data_owner_q;
        data_active_d = data_active_q;
        if (slv_HREADYOUT) begin
            if (mst_can_switch[addr_owner_q] | ~mst_HSEL[addr_owner_q]) begin
                addr_owner_d = winner_w;
            end
            data_owner_d  = addr_owner_q;
            data_active_d = slv_HSEL & slv_HTRANS[1];
        end
    end

    // Owner state registers; reset parks the bus on master 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_q  <= '0;
            data_owner_q  <= '0;
            data_active_q <= 1'b0;
        end else begin
            addr_owner_q  <= addr_owner_d;
            data_owner_q  <= data_owner_d;
            data_active_q <= data_active_d;
        end
    end

    // Grant and response vectors decoded from registered owners only.
    always_comb begin
        master_granted = '0;
        mst_HRESP      = '0;
        for (int m = 0; m < MASTERS; m++) begin
            master_granted[m] = (addr_owner_q == m[MASTER_BITS-1:0]);
            mst_HRESP[m]      = slv_HRESP & data_active_q &
                                (data_owner_q == m[MASTER_BITS-1:0]);
        end
    end

    // Address/control from the address owner; an unselected owner shows IDLE.
    assign slv_HSEL      = mst_HSEL[addr_owner_q];
    assign slv_HADDR     = mst_HADDR[addr_owner_q];
    assign slv_HWRITE    = mst_HWRITE[addr_owner_q];
    assign slv_HSIZE     = mst_HSIZE[addr_owner_q];
    assign slv_HBURST    = mst_HBURST[addr_owner_q];
    assign slv_HPROT     = mst_HPROT[addr_owner_q];
    assign slv_HMASTLOCK = mst_HMASTLOCK[addr_owner_q];
    assign slv_HTRANS    = mst_HSEL[addr_owner_q] ? mst_HTRANS[addr_owner_q] : 2'b00;

    // Write data follows the data-phase owner, one beat behind the address.
    assign slv_HWDATA    = mst_HWDATA[data_owner_q];

    // Single slave on this layer: its ready is the layer ready.
    assign slv_HREADY    = slv_HREADYOUT;
    assign mst_HRDATA    = slv_HRDATA;
    assign mst_HREADYOUT = slv_HREADYOUT;

endmodule

`default_nettype wire
